cpu_ad48_dmem_arb: RTL and testbench

- Round-robin arbiter that shares the single-port 48-bit data memory (DMEM) of cpu_ad48 between NREQ requesters.
- Default requesters: the CPU load/store unit (port 0) and a debug/loader port (port 1).
- Accepts at most one transaction per cycle, routes the 1-cycle-latency read data back to the winning requester, and supports locked sequences for atomic read-modify-write.
- Sits between the requesters and DMEM inside cpu_ad48.

---
 rtl/cpu_ad48_pkg.sv | 14 +
 rtl/cpu_ad48_rr_pick.sv | 34 +++
 rtl/cpu_ad48_dmem_arb.sv | 124 ++++++++++++
 tb/tb_cpu_ad48_dmem_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ad48_pkg.sv
// Shared constants for the cpu_ad48 data-memory path: word width,
// requester indices and the arbiter lock-state encoding.
package cpu_ad48_pkg;

   localparam int unsigned DW      = 48;
   localparam int unsigned REQ_CPU = 0;
   localparam int unsigned REQ_DBG = 1;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/cpu_ad48_rr_pick.sv
// Combinational round-robin picker: first eligible (valid & mask) requester
// at or after ptr, wrapping at NREQ-1, as a one-hot grant plus its index.
module cpu_ad48_rr_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IW   = 1
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IW-1:0]   ptr,
   input  logic [NREQ-1:0] mask,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);

   logic [NREQ-1:0] elig;
   logic            found;
   int unsigned     j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      elig  = valid & mask;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = (32'(ptr) + k) % NREQ;
         if (!found && elig[j]) begin
            grant[j] = 1'b1;
            idx      = IW'(j);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cpu_ad48_dmem_arb.sv
// Round-robin arbiter sharing the single-port DMEM between NREQ requesters,
// with locked sequences for atomic read-modify-write and 1-cycle responses.
module cpu_ad48_dmem_arb
   import cpu_ad48_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = 6,
   parameter int unsigned DW   = cpu_ad48_pkg::DW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ-1:0]   req_we,
   input  logic [NREQ-1:0]   req_lock,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [DW-1:0]     rsp_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t      state, state_nxt;
   logic [IW-1:0]   owner, owner_nxt;
   logic [IW-1:0]   ptr, ptr_nxt;
   logic [NREQ-1:0] rsp_q;
   logic            rd_q;

   logic [NREQ-1:0] mask, pick_grant, grant;
   logic [IW-1:0]   pick_idx, idx_inc;
   logic            sel_we, sel_lock;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;

   // While locked, only the owner is eligible.
   assign mask = (state == ARB_LOCKED) ? (NREQ'(1) << owner) : '1;

   cpu_ad48_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .valid (req_valid),
      .ptr   (ptr),
      .mask  (mask),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   assign grant     = rst ? '0 : pick_grant;
   assign req_ready = grant;

   always_comb begin
      sel_we    = 1'b0;
      sel_lock  = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_we    = req_we[i];
            sel_lock  = req_lock[i];
            sel_addr  = req_addr[i*AW +: AW];
            sel_wdata = req_wdata[i*DW +: DW];
         end
      end
   end

   assign mem_en    = |grant;
   assign mem_we    = sel_we;
   assign mem_addr  = sel_addr;
   assign mem_wdata = sel_wdata;

   assign idx_inc = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      if (mem_en) begin
         case (state)
            ARB_IDLE: begin
               ptr_nxt = idx_inc;
               if (sel_lock) begin
                  state_nxt = ARB_LOCKED;
                  owner_nxt = pick_idx;
               end
            end
            ARB_LOCKED: begin
               if (!sel_lock) begin
                  state_nxt = ARB_IDLE;
                  ptr_nxt   = idx_inc;
               end
            end
            default: state_nxt = ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB_IDLE;
         owner <= '0;
         ptr   <= '0;
         rsp_q <= '0;
         rd_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         ptr   <= ptr_nxt;
         rsp_q <= grant;
         rd_q  <= mem_en & ~sel_we;
      end
   end

   // Gated by rst so a response falling due in the reset cycle never shows.
   assign rsp_valid = rsp_q & ~{NREQ{rst}};
   assign rsp_rdata = (rd_q && !rst) ? mem_rdata : '0;

endmodule

// File: tb/tb_cpu_ad48_dmem_arb.sv
// Directed bench for cpu_ad48_dmem_arb with a write-first 1-cycle DMEM model.
module tb_cpu_ad48_dmem_arb;
   import cpu_ad48_pkg::*;

   localparam int unsigned NREQ = 2;
   localparam int unsigned AW   = 6;
   localparam int unsigned W    = 48;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_ready, req_we, req_lock, rsp_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*W-1:0] req_wdata;
   logic [W-1:0]      rsp_rdata, mem_wdata, mem_rdata;
   logic              mem_en, mem_we;
   logic [AW-1:0]     mem_addr;

   logic [W-1:0]      dmem [64];
   int                nchk = 0;
   int                nerr = 0;
   int                cnt0, cnt1;
   logic [1:0]        exp_g, prev_g;

   cpu_ad48_dmem_arb #(.NREQ(NREQ), .AW(AW), .DW(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_lock  (req_lock),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 64; i++) dmem[i] = '0;
      dmem[1]  = 48'h111111111111;
      dmem[2]  = 48'h222222222222;
      dmem[3]  = 48'h333333333333;
      dmem[4]  = 48'h444444444444;
      dmem[5]  = 48'h123456789ABC;
      dmem[20] = 48'h202020202020;
      mem_rdata = '0;
   end

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            dmem[mem_addr] <= mem_wdata;
            mem_rdata      <= mem_wdata;
         end else begin
            mem_rdata <= dmem[mem_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int unsigned r, input logic v, input logic we, input logic lock,
                        input logic [AW-1:0] a, input logic [W-1:0] d);
      req_valid[r]        = v;
      req_we[r]           = we;
      req_lock[r]         = lock;
      req_addr[r*AW +: AW] = a;
      req_wdata[r*W +: W] = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
      step; step;
      req_valid = 2'b11;
      #1;
      check("rst_ready", 64'(req_ready), 0);
      check("rst_mem_en", 64'(mem_en), 0);
      check("rst_rsp_valid", 64'(rsp_valid), 0);
      check("rst_rsp_rdata", 64'(rsp_rdata), 0);
      step;
      rst = 1'b0;
      req_valid = '0;

      // single read
      step;
      drive(REQ_CPU, 1, 0, 0, 6'd5, '0);
      #1;
      check("rd_ready", 64'(req_ready), 64'b01);
      check("rd_mem_en", 64'(mem_en), 1);
      check("rd_mem_addr", 64'(mem_addr), 5);
      check("rd_rsp_early", 64'(rsp_valid), 0);
      step;
      req_valid = '0;
      #1;
      check("rd_rsp_valid", 64'(rsp_valid), 64'b01);
      check("rd_rsp_rdata", 64'(rsp_rdata), 64'h123456789ABC);
      rst = 1'b1;
      step;
      rst = 1'b0;

      // fairness: both continuously valid
      cnt0 = 0; cnt1 = 0; prev_g = '0;
      drive(REQ_CPU, 1, 0, 0, 6'd1, '0);
      drive(REQ_DBG, 1, 0, 0, 6'd2, '0);
      for (int c = 0; c < 6; c++) begin
         #1;
         exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
         check("fair_ready", 64'(req_ready), 64'(exp_g));
         check("fair_onehot", 64'($countones(req_ready) <= 1), 1);
         if (c > 0) begin
            check("fair_rsp_valid", 64'(rsp_valid), 64'(prev_g));
            check("fair_rsp_rdata", 64'(rsp_rdata),
                  prev_g[0] ? 64'h111111111111 : 64'h222222222222);
         end
         cnt0 += int'(rsp_valid[0]);
         cnt1 += int'(rsp_valid[1]);
         prev_g = exp_g;
         step;
      end
      req_valid = '0;
      #1;
      check("fair_last_rsp", 64'(rsp_valid), 64'b10);
      check("fair_last_rdata", 64'(rsp_rdata), 64'h222222222222);
      cnt0 += int'(rsp_valid[0]);
      cnt1 += int'(rsp_valid[1]);
      check("fair_cnt0", 64'(cnt0), 3);
      check("fair_cnt1", 64'(cnt1), 3);

      // write then read same address
      drive(REQ_DBG, 1, 1, 0, 6'd10, 48'hFFFFFFFFFFF9);
      #1;
      check("wr_ready", 64'(req_ready), 64'b10);
      check("wr_mem_we", 64'(mem_we), 1);
      step;
      drive(REQ_DBG, 1, 0, 0, 6'd10, '0);
      #1;
      check("wrrd_ready", 64'(req_ready), 64'b10);
      check("wr_rsp_valid", 64'(rsp_valid), 64'b10);
      check("wr_rsp_rdata", 64'(rsp_rdata), 0);
      step;
      req_valid = '0;
      #1;
      check("wrrd_rsp_valid", 64'(rsp_valid), 64'b10);
      check("wrrd_rsp_rdata", 64'(rsp_rdata), 64'hFFFFFFFFFFF9);

      // locked read-modify-write
      drive(REQ_CPU, 1, 0, 1, 6'd3, '0);
      drive(REQ_DBG, 1, 0, 0, 6'd4, '0);
      #1;
      check("lk0_ready", 64'(req_ready), 64'b01);
      step;
      req_valid[0] = 1'b0;
      #1;
      check("lk1_ready", 64'(req_ready), 0);
      check("lk1_mem_en", 64'(mem_en), 0);
      check("lk1_rsp_valid", 64'(rsp_valid), 64'b01);
      check("lk1_rsp_rdata", 64'(rsp_rdata), 64'h333333333333);
      step;
      #1;
      check("lk2_ready", 64'(req_ready), 0);
      check("lk2_rsp_valid", 64'(rsp_valid), 0);
      step;
      drive(REQ_CPU, 1, 1, 0, 6'd3, 48'hA5A5A5A5A5A5);
      #1;
      check("lk3_ready", 64'(req_ready), 64'b01);
      check("lk3_mem_we", 64'(mem_we), 1);
      step;
      req_valid[0] = 1'b0;
      #1;
      check("lk4_ready", 64'(req_ready), 64'b10);
      check("lk4_rsp_valid", 64'(rsp_valid), 64'b01);
      check("lk4_rsp_rdata", 64'(rsp_rdata), 0);
      step;
      req_valid = '0;
      #1;
      check("lk5_rsp_valid", 64'(rsp_valid), 64'b10);
      check("lk5_rsp_rdata", 64'(rsp_rdata), 64'h444444444444);
      check("lk_dmem3", 64'(dmem[3]), 64'hA5A5A5A5A5A5);

      // reset mid-operation: rr_ptr restart and dropped write
      drive(REQ_CPU, 1, 0, 0, 6'd5, '0);
      #1;
      check("rsta_ready", 64'(req_ready), 64'b01);
      step;
      rst = 1'b1;
      drive(REQ_CPU, 1, 1, 0, 6'd20, 48'hDEADBEEF0000);
      #1;
      check("rsta_rsp_sup", 64'(rsp_valid), 0);
      check("rsta_mem_en", 64'(mem_en), 0);
      check("rsta_ready0", 64'(req_ready), 0);
      step;
      rst = 1'b0;
      drive(REQ_CPU, 1, 0, 0, 6'd1, '0);
      drive(REQ_DBG, 1, 0, 0, 6'd2, '0);
      #1;
      check("rsta_ptr", 64'(req_ready), 64'b01);
      check("rsta_rsp_after", 64'(rsp_valid), 0);

      // reset releases a lock held by requester 1
      step;
      req_valid = 2'b10;
      req_lock  = 2'b10;
      #1;
      check("rstb_ready", 64'(req_ready), 64'b10);
      step;
      rst = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      #1;
      check("rstb_rsp_sup", 64'(rsp_valid), 0);
      step;
      rst = 1'b0;
      req_valid = 2'b11;
      #1;
      check("rstb_lock_rel", 64'(req_ready), 64'b01);
      step;
      req_valid = '0;
      #1;
      check("rstb_rsp_valid", 64'(rsp_valid), 64'b01);
      check("rstb_rsp_rdata", 64'(rsp_rdata), 64'h111111111111);
      check("rst_dmem20", 64'(dmem[20]), 64'h202020202020);

      // idle
      for (int c = 0; c < 10; c++) begin
         step;
         check("idle_mem_en", 64'(mem_en), 0);
         check("idle_rsp_valid", 64'(rsp_valid), 0);
      end
      check("idle_dmem3", 64'(dmem[3]), 64'hA5A5A5A5A5A5);
      check("idle_dmem5", 64'(dmem[5]), 64'h123456789ABC);
      check("idle_dmem10", 64'(dmem[10]), 64'hFFFFFFFFFFF9);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
